// File: rtl/sonar_scheduler.sv
// rtl/sonar_scheduler.sv - round-robin ultrasonic ranger scheduler
// Triggers one sensor at a time, times its echo and publishes a 9-bit cm distance.
module sonar_scheduler #(
  parameter int unsigned NUM_SENSORS         = 6,
  parameter int unsigned TRIG_CYCLES         = 500,
  parameter int unsigned CYCLES_PER_CM       = 2900,
  parameter int unsigned ECHO_TIMEOUT_CYCLES = 1500000,
  parameter int unsigned GAP_CYCLES          = 250000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_SENSORS-1:0]   sensor_mask,
  input  logic [NUM_SENSORS-1:0]   echo,
  output logic [NUM_SENSORS-1:0]   trigger,
  output logic [9*NUM_SENSORS-1:0] distance_flat,
  output logic [NUM_SENSORS-1:0]   valid,
  output logic [NUM_SENSORS-1:0]   timeout,
  output logic [2:0]               active_sensor,
  output logic                     busy
);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GAP} state_t;

  state_t                   state_q;
  logic [2:0]               active_q;
  logic [NUM_SENSORS-1:0]   trig_q, valid_q, tout_q;
  logic [NUM_SENSORS-1:0]   echo_s1_q, echo_s2_q;
  logic [9*NUM_SENSORS-1:0] dist_q;
  logic                     busy_q;
  logic [31:0]              cnt_q, presc_q;
  logic [8:0]               cm_q;

  logic                     echo_act;
  logic [2:0]               sel_d;
  logic                     pub_d, pub_to_d, start_d;
  logic [8:0]               pub_dist_d;

  function automatic logic [NUM_SENSORS-1:0] onehot(input logic [2:0] idx);
    logic [NUM_SENSORS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Walk backwards so the nearest set bit after cur is the last one written.
  function automatic logic [2:0] next_sel(input logic [2:0] cur, input logic [NUM_SENSORS-1:0] m);
    logic [2:0] r;
    int unsigned idx;
    r = cur;
    for (int unsigned k = NUM_SENSORS; k >= 1; k--) begin
      idx = (32'(cur) + k) % NUM_SENSORS;
      if (m[idx[2:0]]) r = idx[2:0];
    end
    return r;
  endfunction

  always_comb begin
    echo_act   = echo_s2_q[active_q];
    sel_d      = next_sel(active_q, sensor_mask);
    start_d    = enable && (sensor_mask != '0);
    pub_d      = 1'b0;
    pub_to_d   = 1'b0;
    pub_dist_d = cm_q;
    case (state_q)
      S_WAIT_RISE: if (!echo_act && cnt_q == ECHO_TIMEOUT_CYCLES - 1) begin
        pub_d = 1'b1; pub_to_d = 1'b1; pub_dist_d = 9'h1FF;
      end
      S_MEASURE: if (!echo_act) begin
        pub_d = 1'b1;
      end else if (cnt_q == ECHO_TIMEOUT_CYCLES - 1) begin
        pub_d = 1'b1; pub_to_d = 1'b1; pub_dist_d = 9'h1FF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      active_q  <= '0;
      trig_q    <= '0;
      valid_q   <= '0;
      tout_q    <= '0;
      dist_q    <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      presc_q   <= '0;
      cm_q      <= '0;
      echo_s1_q <= '0;
      echo_s2_q <= '0;
    end else begin
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      valid_q   <= '0;
      if (pub_d) begin
        for (int i = 0; i < NUM_SENSORS; i++) begin
          if (3'(i) == active_q) begin
            dist_q[9*i +: 9] <= pub_dist_d;
            tout_q[i]        <= pub_to_d;
          end
        end
        valid_q <= onehot(active_q);
        state_q <= S_GAP;
        cnt_q   <= '0;
      end
      case (state_q)
        S_IDLE: if (start_d) begin
          active_q <= sel_d;
          trig_q   <= onehot(sel_d);
          cnt_q    <= '0;
          busy_q   <= 1'b1;
          state_q  <= S_TRIG;
        end
        S_TRIG: if (cnt_q == TRIG_CYCLES - 1) begin
          trig_q  <= '0;
          cnt_q   <= '0;
          state_q <= S_WAIT_RISE;
        end else begin
          cnt_q <= cnt_q + 1;
        end
        // The rise-detect cycle already counts as one cycle of echo-high time.
        S_WAIT_RISE: if (echo_act) begin
          cnt_q   <= 32'd1;
          presc_q <= 32'd1;
          cm_q    <= '0;
          state_q <= S_MEASURE;
        end else if (!pub_d) begin
          cnt_q <= cnt_q + 1;
        end
        S_MEASURE: if (!pub_d) begin
          cnt_q <= cnt_q + 1;
          if (presc_q == CYCLES_PER_CM - 1) begin
            presc_q <= '0;
            if (cm_q != 9'h1FF) cm_q <= cm_q + 9'd1;
          end else begin
            presc_q <= presc_q + 1;
          end
        end
        S_GAP: if (cnt_q == GAP_CYCLES - 1) begin
          cnt_q <= '0;
          if (start_d) begin
            active_q <= sel_d;
            trig_q   <= onehot(sel_d);
            state_q  <= S_TRIG;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end else begin
          cnt_q <= cnt_q + 1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trigger       = trig_q;
  assign distance_flat = dist_q;
  assign valid         = valid_q;
  assign timeout       = tout_q;
  assign active_sensor = active_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb/tb_sonar_scheduler.sv - randomized self-checking bench for sonar_scheduler
// Reference model: next sensor from mask, distance = floor(width/cm) or 511 on timeout.
module tb_sonar_scheduler;
  localparam int T   = 4;
  localparam int CPC = 10;
  localparam int TO  = 2000;
  localparam int GAP = 20;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [5:0]  sensor_mask = '0;
  logic [5:0]  echo = '0;
  logic [5:0]  trigger, valid, timeout;
  logic [53:0] distance_flat;
  logic [2:0]  active_sensor;
  logic        busy;

  sonar_scheduler #(
    .NUM_SENSORS(6), .TRIG_CYCLES(T), .CYCLES_PER_CM(CPC),
    .ECHO_TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .sensor_mask(sensor_mask),
    .echo(echo), .trigger(trigger), .distance_flat(distance_flat), .valid(valid),
    .timeout(timeout), .active_sensor(active_sensor), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_dist[6];
  bit exp_to[6];
  int cur = 0;
  bit have_prev = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int next_of(input int c, input logic [5:0] m);
    for (int k = 1; k <= 6; k++) if (m[(c + k) % 6]) return (c + k) % 6;
    return c;
  endfunction

  function automatic logic [53:0] model_flat();
    logic [53:0] f;
    f = '0;
    for (int i = 0; i < 6; i++) f[9*i +: 9] = 9'(exp_dist[i]);
    return f;
  endfunction

  function automatic logic [5:0] model_to();
    logic [5:0] t;
    for (int i = 0; i < 6; i++) t[i] = exp_to[i];
    return t;
  endfunction

  // One measurement: w>0 echo width, w==0 no echo, w<0 echo stuck high (left asserted).
  task automatic meas(input int d, input int w, input bit drop_en);
    int n, nv, len, s, t_rise, bad;
    logic [5:0] oh;
    n = 0;
    while (trigger == '0 && n < 6000) begin @(negedge CLOCK_50); n++; end
    if (n >= 6000) begin chk("trig_wait", 0, 1); return; end
    if (have_prev) chk("gap_len", (n + 1 >= GAP), 1);
    s = next_of(cur, sensor_mask);
    cur = s;
    oh = 6'(1 << s);
    t_rise = cyc;
    chk("trig_sel", trigger, oh);
    chk("active", active_sensor, s);
    len = 0; bad = 0;
    while (trigger != '0 && len < 100) begin
      if (trigger !== oh) bad++;
      len++;
      @(negedge CLOCK_50);
    end
    chk("trig_onehot", bad, 0);
    chk("trig_len", len, T);
    repeat (d) begin echo = 6'($urandom) & ~oh; @(negedge CLOCK_50); end
    echo = '0;
    nv = 0;
    fork
      begin
        if (w > 0) begin
          echo[s] = 1'b1;
          for (int i = 0; i < w; i++) begin
            @(negedge CLOCK_50);
            if (drop_en && i == 10) enable = 1'b0;
          end
          echo[s] = 1'b0;
        end else if (w < 0) echo[s] = 1'b1;
      end
      begin
        while (valid == '0 && nv < 5000) begin @(negedge CLOCK_50); nv++; end
      end
    join
    if (nv >= 5000) begin chk("valid_wait", 0, 1); return; end
    if (w <= 0 || w >= TO) begin exp_dist[s] = 511; exp_to[s] = 1; end
    else begin exp_dist[s] = w / CPC; exp_to[s] = 0; end
    if (w == 0) chk("to_latency", (cyc - t_rise >= 2002 && cyc - t_rise <= 2006), 1);
    chk("valid", valid, oh);
    chk("dist", distance_flat, model_flat());
    chk("timeout", timeout, model_to());
    @(negedge CLOCK_50);
    chk("valid_pulse", valid, 0);
    have_prev = 1;
  endtask

  initial begin
    int bad, r, w;
    for (int i = 0; i < 6; i++) begin exp_dist[i] = 0; exp_to[i] = 0; end
    repeat (3) @(negedge CLOCK_50);
    chk("rst_trig", trigger, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dist", distance_flat, 0);
    chk("rst_flags", {valid, timeout, active_sensor}, 0);
    reset = 1'b1;
    @(negedge CLOCK_50);

    sensor_mask = 6'b000001; enable = 1'b1;
    meas(5, 123, 0);
    chk("basic_dist", distance_flat[8:0], 12);

    sensor_mask = 6'b101010;
    for (int i = 0; i < 6; i++) meas(5, 50, 0);

    sensor_mask = 6'b000100;
    meas(5, 0, 0);
    meas(3, 30, 0);

    sensor_mask = 6'b010001;
    meas(3, -1, 0);
    meas(4, 75, 0);
    echo = '0;

    for (int i = 0; i < 10; i++) begin
      sensor_mask = 6'($urandom_range(1, 63));
      r = $urandom_range(0, 9);
      w = (r == 0) ? 0 : 10 * $urandom_range(0, 40) + 5;
      meas($urandom_range(0, 20), w, 0);
    end

    meas(2, 85, 1);
    repeat (GAP + 3) @(negedge CLOCK_50);
    chk("drop_en_busy", busy, 0);
    chk("drop_en_trig", trigger, 0);

    sensor_mask = '0; enable = 1'b1;
    bad = 0;
    repeat (10000) begin
      @(negedge CLOCK_50);
      if (busy || trigger != '0) bad++;
    end
    chk("mask0_idle", bad, 0);

    sensor_mask = 6'b000011;
    bad = 0;
    while (trigger == '0 && bad < 100) begin @(negedge CLOCK_50); bad++; end
    chk("rst_trig_seen", trigger != '0, 1);
    @(negedge CLOCK_50);
    #2 reset = 1'b0;
    #1;
    chk("arst_trig", trigger, 0);
    chk("arst_valid", valid, 0);
    chk("arst_dist", distance_flat, 0);
    chk("arst_busy", busy, 0);
    @(negedge CLOCK_50);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonar_scheduler.md
Name: sonar_scheduler

Overview:
- Sequences the six ultrasonic rangers (trigger/echo pairs on GPIO_0) one at a time in round-robin order, so that only one sensor is ever pinging and crosstalk is eliminated.
- For the active sensor it generates the trigger pulse, times the echo, converts the echo width to centimetres and publishes a per-sensor 9-bit distance.
- It replaces free-running per-sensor triggering inside the sonar network. Its distance outputs feed the FL/FR/R/BR/BL/L SensorInCM signals to the processor.

Parameters:
- NUM_SENSORS, 6: number of trigger/echo pairs; the sensor index is 3 bits wide.
- TRIG_CYCLES, 500: trigger high time in clocks (10 us at 50 MHz).
- CYCLES_PER_CM, 2900: clocks of echo-high time per centimetre (58 us).
- ECHO_TIMEOUT_CYCLES, 1500000: maximum wait for an echo edge, and maximum echo-high time (30 ms).
- GAP_CYCLES, 250000: quiet time after each measurement, before the next trigger (5 ms).

Ports:
- CLOCK_50, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: run the scan; when low, the block parks in IDLE after finishing the current measurement.
- sensor_mask, input, 6: bit i=1 includes sensor i in the rotation.
- echo, input, 6: raw echo lines, asynchronous to CLOCK_50.
- trigger, output, 6: trigger lines; at most one bit is high at any time.
- distance_flat, output, 54: sensor i distance in cm at bits [9i+8:9i]; range 0..511.
- valid, output, 6: one-cycle pulse on bit i when distance i updates.
- timeout, output, 6: sticky per sensor; set when the last measurement timed out, cleared by the next good measurement.
- active_sensor, output, 3: index of the sensor currently being serviced.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-low): all outputs go to 0, the FSM enters IDLE, and all counters clear. Reset asserted mid-measurement drops trigger immediately and discards the partial result.
- Echo synchronisation: each echo bit passes through a 2-flop synchroniser before use, adding 2 cycles of latency. The measured width equals the true width to within ±1 clock.
- IDLE:
  - If enable=1 and sensor_mask≠0, pick the next sensor and go to TRIG.
  - Next sensor = first set mask bit strictly after active_sensor, wrapping modulo 6. After reset, active_sensor=0, so the search starts at index 1; a mask of 6'b000001 still selects index 0 via the wrap.
  - If the mask is 0, stay in IDLE with busy=0.
- TRIG: trigger[active_sensor]=1 for exactly TRIG_CYCLES clocks, then go to WAIT_RISE.
- WAIT_RISE: wait for synchronised echo[active]=1, then go to MEASURE.
  - If ECHO_TIMEOUT_CYCLES clocks elapse with no rise: distance=511, timeout bit set, valid pulse, go to GAP.
- MEASURE:
  - A prescaler counts 0..CYCLES_PER_CM-1. On wrap, the cm counter increments, saturating at 511.
  - On the echo falling edge: distance=cm counter, timeout bit cleared, valid pulse, go to GAP. The partial-cm remainder is truncated.
  - If echo stays high for ECHO_TIMEOUT_CYCLES: distance=511, timeout bit set, valid pulse, go to GAP.
- GAP:
  - Hold for GAP_CYCLES clocks with all triggers low.
  - Then, if enable=1 and mask≠0, select the next sensor and go to TRIG; otherwise go to IDLE.
- Output update rules:
  - distance and the timeout bit update in the same cycle as the valid pulse.
  - Other sensors' distances hold their last values.
- Mask changes: sampled only at selection points, never mid-measurement. Clearing the active sensor's bit mid-measurement still completes and publishes that measurement.
- enable deasserted mid-measurement: the current measurement completes through GAP, then the FSM goes to IDLE.
- Echo on non-active sensors: ignored entirely.
- Single-bit mask: the same sensor is serviced repeatedly, spaced by GAP.
- Ordering guarantee: no trigger rises until GAP_CYCLES have elapsed since the previous measurement ended.

Test Plan:
- Common setup: test parameters TRIG_CYCLES=4, CYCLES_PER_CM=10, ECHO_TIMEOUT_CYCLES=2000, GAP_CYCLES=20.
- Basic measurement: mask=6'b000001, enable=1. Drive echo[0] high for 123 clocks, starting 5 clocks after trigger falls.
  - Required: trigger[0] high for exactly 4 clocks; valid[0] pulses once; distance[0]=12; timeout[0]=0.
- Rotation: mask=6'b101010, give each active sensor a 50-clock echo.
  - Required: trigger sequence 1,3,5,1,3,5; no overlap between triggers; at least 20 idle clocks between measurements; each distance = 5.
- Timeouts:
  - No echo on sensor 2 (mask=6'b000100): distance[2]=511, timeout[2]=1 about 2004 clocks after trigger rise.
  - A subsequent 30-clock echo: distance[2]=3, timeout[2]=0.
- Stuck-high echo: echo[4] held high for 3000 clocks → distance[4]=511, timeout[4]=1, and the FSM still advances to the next sensor.
- Mid-operation control:
  - Deassert enable during MEASURE: the measurement completes, valid pulses, then busy=0 after GAP.
  - Assert reset during TRIG: trigger=0, valid=0 and all distances=0 immediately, asynchronously to the clock.
- Mask=0 with enable=1: busy stays 0 and trigger stays 0 for 10000 clocks.
